// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU encodings, FSM states and instruction fields for the 8-bit CPU
package cpu_pkg;

  localparam logic [7:0] PC_RESET = 8'h00;

  // Opcode field values (instruction bits [7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation encodings shared with the ALU
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_A = 3'd5;

  // Instruction field bit positions
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS1_BIT = 1;
  localparam int RS2_BIT = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_IMM,
    ST_EXEC,
    ST_HALT
  } cpu_state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LDI,
    CLS_JMP,
    CLS_JZ,
    CLS_HALT
  } instr_class_e;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// rtl/cpu_control_fsm_if.sv - instruction-memory handshake and register-file control bundle
interface cpu_control_fsm_if;

  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic [1:0] Register_Destination;
  logic       Register_1_operand;
  logic       Register_2_operand;
  logic       write_enable;
  logic [2:0] alu_op;
  logic       wb_sel;
  logic [7:0] imm;
  logic       halted;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rdata,
    output Register_Destination, Register_1_operand, Register_2_operand,
    output write_enable, alu_op, wb_sel, imm, halted
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rdata,
    input  Register_Destination, Register_1_operand, Register_2_operand,
    input  write_enable, alu_op, wb_sel, imm, halted
  );

endinterface

// File: rtl/cpu_instr_decode.sv
// rtl/cpu_instr_decode.sv - combinational instruction byte decoder; opcode 9 is JZ only with CTRL_JZ_EN
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0]   instr,
  output instr_class_e cls,
  output logic [1:0]   rd,
  output logic         rs1,
  output logic         rs2,
  output logic [2:0]   alu_op,
  output logic         needs_imm
);

  logic [3:0] opc;

  assign opc = instr[OPC_MSB:OPC_LSB];
  assign rd  = instr[RD_MSB:RD_LSB];
  assign rs1 = instr[RS1_BIT];
  assign rs2 = instr[RS2_BIT];

  // Map opcode to instruction class and ALU operation; unknown opcodes behave as NOP
  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_ADD;
    case (opc)
      OP_NOP:  cls = CLS_NOP;
      OP_ADD:  begin cls = CLS_ALU; alu_op = ALU_ADD;    end
      OP_SUB:  begin cls = CLS_ALU; alu_op = ALU_SUB;    end
      OP_AND:  begin cls = CLS_ALU; alu_op = ALU_AND;    end
      OP_OR:   begin cls = CLS_ALU; alu_op = ALU_OR;     end
      OP_XOR:  begin cls = CLS_ALU; alu_op = ALU_XOR;    end
      OP_MOV:  begin cls = CLS_ALU; alu_op = ALU_PASS_A; end
      OP_LDI:  cls = CLS_LDI;
      OP_JMP:  cls = CLS_JMP;
`ifdef CTRL_JZ_EN
      OP_JZ:   cls = CLS_JZ;
`else
      OP_JZ:   cls = CLS_NOP;
`endif
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

  assign needs_imm = (cls == CLS_LDI) || (cls == CLS_JMP) || (cls == CLS_JZ);

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - fetch/decode/execute controller; CTRL_JZ_EN adds zero_flag and the JZ instruction
module cpu_control_fsm
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef CTRL_JZ_EN
  input  logic zero_flag,
`endif
  cpu_control_fsm_if.master bus
);

  cpu_state_e   state;
  logic [7:0]   pc;
  logic [7:0]   ir;
  logic [7:0]   imm_q;
  logic         mem_req_q;
  logic         we_q;
  logic         wb_q;
  logic         halted_q;
  logic [1:0]   rd_q;
  logic         rs1_q;
  logic         rs2_q;
  logic [2:0]   alu_q;

  logic [7:0]   dec_in;
  instr_class_e dec_cls;
  logic [1:0]   dec_rd;
  logic         dec_rs1;
  logic         dec_rs2;
  logic [2:0]   dec_alu;
  logic         dec_needs_imm;
  logic         jump_taken;

  // The byte being accepted is decoded directly so the fields are already valid in DECODE
  assign dec_in = (state == ST_FETCH) ? bus.mem_rdata : ir;

  cpu_instr_decode u_decode (
    .instr     (dec_in),
    .cls       (dec_cls),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .alu_op    (dec_alu),
    .needs_imm (dec_needs_imm)
  );

  // Jump decision evaluated in EXEC from the held instruction
  always_comb begin
    jump_taken = (dec_cls == CLS_JMP);
`ifdef CTRL_JZ_EN
    if ((dec_cls == CLS_JZ) && zero_flag) begin
      jump_taken = 1'b1;
    end
`endif
  end

  // Main controller: state, program counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= PC_RESET;
      ir        <= 8'h00;
      imm_q     <= 8'h00;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      wb_q      <= 1'b0;
      halted_q  <= 1'b0;
      rd_q      <= 2'd0;
      rs1_q     <= 1'b0;
      rs2_q     <= 1'b0;
      alu_q     <= ALU_ADD;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_req_q) begin
            // First cycle after reset: raise the request
            mem_req_q <= 1'b1;
          end else if (bus.mem_ready) begin
            ir        <= bus.mem_rdata;
            pc        <= pc + 8'd1;
            mem_req_q <= 1'b0;
            rd_q      <= dec_rd;
            rs1_q     <= dec_rs1;
            rs2_q     <= dec_rs2;
            alu_q     <= dec_alu;
            wb_q      <= (dec_cls == CLS_LDI);
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_cls == CLS_HALT) begin
            halted_q <= 1'b1;
            state    <= ST_HALT;
          end else if (dec_needs_imm) begin
            mem_req_q <= 1'b1;
            state     <= ST_IMM;
          end else begin
            we_q  <= (dec_cls == CLS_ALU);
            state <= ST_EXEC;
          end
        end
        ST_IMM: begin
          if (bus.mem_ready) begin
            imm_q     <= bus.mem_rdata;
            pc        <= pc + 8'd1;
            mem_req_q <= 1'b0;
            we_q      <= (dec_cls == CLS_LDI);
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          we_q      <= 1'b0;
          mem_req_q <= 1'b1;
          if (jump_taken) begin
            pc <= imm_q;
          end
          state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req              = mem_req_q;
  assign bus.mem_addr             = pc;
  assign bus.Register_Destination = rd_q;
  assign bus.Register_1_operand   = rs1_q;
  assign bus.Register_2_operand   = rs2_q;
  assign bus.write_enable         = we_q;
  assign bus.alu_op               = alu_q;
  assign bus.wb_sel               = wb_q;
  assign bus.imm                  = imm_q;
  assign bus.halted               = halted_q;

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle fetch/decode/execute controller for the 8-bit CPU, sitting directly upstream of the register file. It fetches 8-bit instructions from instruction memory over a req/ready handshake and decodes them into register-file addresses, ALU opcode and write-back select. It issues the single-cycle write-enable pulse that commits results into the register file.

## Interface
- PC_RESET, 8'h00, program counter value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  instruction-memory read request
- mem_addr  out  8  fetch address
- mem_ready  in  1  memory has valid data on mem_rdata this cycle
- mem_rdata  in  8  fetched byte
- Register_Destination  out  2  destination register address
- Register_1_operand  out  1  source register 1 address
- Register_2_operand  out  1  source register 2 address
- write_enable  out  1  register-file write strobe, one-cycle pulse
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS-A
- wb_sel  out  1  0 = ALU result, 1 = imm to register data_in
- imm  out  8  latched immediate byte
- halted  out  1  high while in HALT state
- zero_flag  in  1  ALU zero result, only when CTRL_JZ_EN is defined

## Operation
- Instruction format: [7:4] opcode, [3:2] rd, [1] rs1, [0] rs2.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <= rs1 op rs2
  - 6 MOV: rd <= rs1, via PASS-A
  - 7 LDI: rd <= next byte
  - 8 JMP: pc <= next byte
  - 9 JZ: conditional jump
  - F HALT
  - All other opcodes execute as NOP.
- States: FETCH, DECODE, IMM, EXEC, HALT.
- FETCH
  - mem_req=1, mem_addr=pc; hold until mem_ready.
  - On mem_ready: latch instruction into ir, pc <= pc+1 (8-bit wrap, 8'hFF -> 8'h00), go to DECODE.
- DECODE
  - Drive address and ALU fields from ir.
  - LDI/JMP/JZ -> IMM; HALT -> HALT; otherwise -> EXEC.
- IMM
  - Second handshake at pc; on mem_ready: imm <= mem_rdata, pc <= pc+1, go to EXEC.
- EXEC
  - ALU ops and MOV: write_enable=1, wb_sel=0.
  - LDI: write_enable=1, wb_sel=1.
  - JMP: pc <= imm.
  - NOP: no effect.
  - Then -> FETCH.
- HALT: absorbing state; only rst leaves it.
- Address/ALU fields are registered from ir and held stable from DECODE through EXEC.

## Timing
- Reset values: mem_req=0, mem_addr=PC_RESET, write_enable=0, Register_* = 0, alu_op=0, wb_sel=0, imm=0, halted=0, state=FETCH.
- With mem_ready asserted in the same cycle as the request:
  - ALU/MOV/NOP: 3 cycles.
  - LDI/JMP/JZ: 4 cycles.
- Each memory wait cycle adds one cycle.
- mem_req stays high until the cycle mem_ready is sampled. It drops in the following cycle, which is DECODE or EXEC.
- mem_addr is stable while mem_req is high.
- write_enable is high only during EXEC; the register file commits on the EXEC→FETCH edge.
- mem_ready while mem_req=0 is ignored.
- rst mid-handshake: mem_req is 0 the cycle after rst is sampled, and any partially fetched byte is discarded.

## Configuration
- CTRL_JZ_EN defined:
  - zero_flag port exists.
  - Opcode 9 = JZ: pc <= imm in EXEC when zero_flag=1; otherwise pc keeps the post-immediate value.
- CTRL_JZ_EN undefined:
  - No zero_flag port.
  - Opcode 9 decodes as an illegal opcode (NOP) and fetches no immediate.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams
  - alu_op encodings
  - state enum
  - instruction field bit positions
- These are shared with the ALU and top level.
- Optional sub-module cpu_instr_decode: purely combinational ir → (class, rd, rs1, rs2, alu_op, needs_imm); the FSM keeps all state.

## Test plan
- Program {8'h16 (ADD R1,R1,R0)}, mem_ready always 1 → write_enable pulses in cycle 3 with Register_Destination=1, alu_op=0, wb_sel=0; pc=1.
- Program {8'h78, 8'h5A} (LDI R2,0x5A) → imm=8'h5A, wb_sel=1, Register_Destination=2 in EXEC; pc=2.
- Program {8'h80, 8'h10} (JMP 0x10) → next mem_addr=8'h10; write_enable never asserted.
- mem_ready held 0 for 5 cycles in FETCH → mem_req and mem_addr stable throughout; instruction completes 5 cycles later than zero-wait.
- Opcode F0 → halted=1 and mem_req=0 permanently; rst → halted=0, mem_addr=PC_RESET next cycle.
- pc=8'hFF fetching NOP → next fetch address 8'h00.
- With CTRL_JZ_EN: JZ 0x20 with zero_flag=0 → falls through to pc+2; with zero_flag=1 → mem_addr=8'h20.
